// File: rtl/dcache_data_array_arb.sv
// dcache_data_array_arb: refill/hit_write/read arbiter for the dcache data array port with refill lock and read starvation guard
module dcache_data_array_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         refill2arb_valid_i,
  output logic         refill2arb_ready_o,
  input  logic [5:0]   refill2arb_index_i,
  input  logic [2:0]   refill2arb_way_i,
  input  logic [1:0]   refill2arb_offset_i,
  input  logic [127:0] refill2arb_wdata_i,
  input  logic         hit_write2arb_valid_i,
  output logic         hit_write2arb_ready_o,
  input  logic [15:0]  hit_write2arb_bwen_i,
  input  logic [5:0]   hit_write2arb_index_i,
  input  logic [2:0]   hit_write2arb_way_i,
  input  logic [1:0]   hit_write2arb_offset_i,
  input  logic [127:0] hit_write2arb_wdata_i,
  input  logic         read2arb_valid_i,
  output logic         read2arb_ready_o,
  input  logic [5:0]   read2arb_index_i,
  input  logic [2:0]   read2arb_way_i,
  input  logic [1:0]   read2arb_offset_i,
  output logic         arb2read_rvalid_o,
  output logic [127:0] arb2read_rdata_o,
  output logic         arb2data_array_valid_o,
  output logic         arb2data_array_wen_o,
  output logic [15:0]  arb2data_array_bwen_o,
  output logic [5:0]   arb2data_array_index_o,
  output logic [2:0]   arb2data_array_way_o,
  output logic [1:0]   arb2data_array_offset_o,
  output logic [127:0] arb2data_array_wdata_o,
  input  logic [127:0] data_array2arb_rdata_i
);
  typedef enum logic {ARB, LOCK} state_e;
  state_e      state_q, state_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rvalid_q;
  logic        force_rd, gnt_ref, gnt_hw, gnt_rd;
  always_comb begin
    force_rd = state_q == ARB && read2arb_valid_i && starve_cnt_q == 4'(STARVE_MAX);
    gnt_ref  = reset_i && refill2arb_valid_i && !force_rd;
    gnt_hw   = reset_i && state_q == ARB && hit_write2arb_valid_i && !refill2arb_valid_i && !force_rd;
    gnt_rd   = reset_i && state_q == ARB && read2arb_valid_i &&
               (force_rd || (!refill2arb_valid_i && !hit_write2arb_valid_i));
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (gnt_ref) begin
      beat_cnt_d = beat_cnt_q + 2'd1;
      state_d    = (state_q == LOCK && beat_cnt_q == 2'd3) ? ARB : LOCK;
    end
    starve_cnt_d = (!read2arb_valid_i || gnt_rd) ? 4'd0 :
                   (state_q == LOCK || starve_cnt_q == 4'(STARVE_MAX)) ? starve_cnt_q :
                   starve_cnt_q + 4'd1;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= ARB;
      beat_cnt_q   <= 2'd0;
      starve_cnt_q <= 4'd0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= gnt_rd;
    end
  end
  assign refill2arb_ready_o      = gnt_ref;
  assign hit_write2arb_ready_o   = gnt_hw;
  assign read2arb_ready_o        = gnt_rd;
  // a return in flight when reset asserts is dropped immediately
  assign arb2read_rvalid_o       = rvalid_q && reset_i;
  assign arb2read_rdata_o        = data_array2arb_rdata_i;
  assign arb2data_array_valid_o  = gnt_ref || gnt_hw || gnt_rd;
  assign arb2data_array_wen_o    = gnt_ref || gnt_hw;
  assign arb2data_array_bwen_o   = gnt_ref ? 16'hFFFF : gnt_hw ? hit_write2arb_bwen_i : 16'h0;
  assign arb2data_array_wdata_o  = gnt_ref ? refill2arb_wdata_i : gnt_hw ? hit_write2arb_wdata_i : '0;
  assign arb2data_array_index_o  = gnt_ref ? refill2arb_index_i : gnt_hw ? hit_write2arb_index_i :
                                   gnt_rd ? read2arb_index_i : 6'd0;
  assign arb2data_array_way_o    = gnt_ref ? refill2arb_way_i : gnt_hw ? hit_write2arb_way_i :
                                   gnt_rd ? read2arb_way_i : 3'd0;
  assign arb2data_array_offset_o = gnt_ref ? refill2arb_offset_i : gnt_hw ? hit_write2arb_offset_i :
                                   gnt_rd ? read2arb_offset_i : 2'd0;
endmodule

// File: tb/tb_dcache_data_array_arb.sv
// tb_dcache_data_array_arb: table-driven grant/payload checks plus reset and same-location sequences
module tb_dcache_data_array_arb;
  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  logic rf_v = 0, hw_v = 0, rd_v = 0;
  logic rf_rdy, hw_rdy, rd_rdy;
  logic [5:0] rf_idx = 6'd10, hw_idx = 6'd20, rd_idx = 6'd5;
  logic [2:0] rf_way = 3'd3, hw_way = 3'd4, rd_way = 3'd2;
  logic [1:0] rf_off = 2'd0, hw_off = 2'd2, rd_off = 2'd1;
  logic [127:0] rf_wd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  logic [127:0] hw_wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
  logic [15:0] hw_bw = 16'h0F0F;
  logic rvalid, arr_v, arr_wen;
  logic [127:0] rdata, arr_wd, arr_rd, wm, p, w;
  logic [15:0] arr_bw;
  logic [5:0] arr_idx;
  logic [2:0] arr_way;
  logic [1:0] arr_off;
  logic [127:0] mem [2048];
  bit [2047:0] wr_flag;
  int checks = 0, errors = 0;
  logic [1:0] rbeat;

  typedef struct packed {
    logic rf, hw, rd;
    logic erf, ehw, erd;
    logic erv;
  } vec_t;
  vec_t vecs [34];

  dcache_data_array_arb #(.STARVE_MAX(4)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .refill2arb_valid_i(rf_v), .refill2arb_ready_o(rf_rdy), .refill2arb_index_i(rf_idx),
    .refill2arb_way_i(rf_way), .refill2arb_offset_i(rf_off), .refill2arb_wdata_i(rf_wd),
    .hit_write2arb_valid_i(hw_v), .hit_write2arb_ready_o(hw_rdy), .hit_write2arb_bwen_i(hw_bw),
    .hit_write2arb_index_i(hw_idx), .hit_write2arb_way_i(hw_way), .hit_write2arb_offset_i(hw_off),
    .hit_write2arb_wdata_i(hw_wd),
    .read2arb_valid_i(rd_v), .read2arb_ready_o(rd_rdy), .read2arb_index_i(rd_idx),
    .read2arb_way_i(rd_way), .read2arb_offset_i(rd_off),
    .arb2read_rvalid_o(rvalid), .arb2read_rdata_o(rdata),
    .arb2data_array_valid_o(arr_v), .arb2data_array_wen_o(arr_wen), .arb2data_array_bwen_o(arr_bw),
    .arb2data_array_index_o(arr_idx), .arb2data_array_way_o(arr_way),
    .arb2data_array_offset_o(arr_off), .arb2data_array_wdata_o(arr_wd),
    .data_array2arb_rdata_i(arr_rd)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [127:0] pat(input logic [10:0] a);
    return {4{{21'h0, a} ^ 32'hA5A5_0000}};
  endfunction

  always_comb begin
    wm = wr_flag[{arr_idx, arr_way, arr_off}] ? mem[{arr_idx, arr_way, arr_off}] : pat({arr_idx, arr_way, arr_off});
    for (int b = 0; b < 16; b++) if (arr_bw[b]) wm[b*8 +: 8] = arr_wd[b*8 +: 8];
  end

  always @(posedge clock_i) begin
    if (arr_v && arr_wen) begin
      mem[{arr_idx, arr_way, arr_off}] <= wm;
      wr_flag[{arr_idx, arr_way, arr_off}] <= 1'b1;
    end
    if (arr_v && !arr_wen) arr_rd <= wm;
  end

  function automatic logic [156:0] exp_pay(input logic g_rf, g_hw, g_rd, input logic [1:0] roff);
    if (g_rf) return {1'b1, 1'b1, 16'hFFFF, rf_idx, rf_way, roff, rf_wd};
    if (g_hw) return {1'b1, 1'b1, hw_bw, hw_idx, hw_way, hw_off, hw_wd};
    if (g_rd) return {1'b1, 1'b0, 16'h0, rd_idx, rd_way, rd_off, 128'h0};
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [156:0] act, input logic [156:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rdy(input string nm, input logic [2:0] exp);
    chk(nm, {rf_rdy, hw_rdy, rd_rdy}, exp);
  endtask

  initial begin
    vecs = '{7'b0010010, 7'b0000001, 7'b1111000, 7'b1111000, 7'b1111000, 7'b1111000,
             7'b0110100, 7'b0010010, 7'b0000001, 7'b1001000, 7'b1101000, 7'b0100000,
             7'b0100000, 7'b0100000, 7'b1101000, 7'b1101000, 7'b0100100, 7'b0000000,
             7'b0110100, 7'b0110100, 7'b0110100, 7'b0110100, 7'b0110010, 7'b0100101,
             7'b0110100, 7'b0110100, 7'b0110100, 7'b0110100, 7'b1110010, 7'b1101001,
             7'b1101000, 7'b1001000, 7'b1001000, 7'b0100100};
    @(negedge clock_i);
    rf_v = 1; hw_v = 1; rd_v = 1;
    #1 rdy("reset readies", 3'b000);
    chk("reset array valid", arr_v, 1'b0);
    @(negedge clock_i);
    #1 chk("reset rvalid", rvalid, 1'b0);
    @(negedge clock_i);
    reset_i = 1; rf_v = 0; hw_v = 0; rd_v = 0;
    rbeat = 2'd0;
    for (int i = 0; i < 34; i++) begin
      if (i > 0) @(negedge clock_i);
      rf_v = vecs[i].rf; hw_v = vecs[i].hw; rd_v = vecs[i].rd; rf_off = rbeat;
      #1;
      rdy($sformatf("row%0d ready", i), {vecs[i].erf, vecs[i].ehw, vecs[i].erd});
      chk($sformatf("row%0d rvalid", i), rvalid, vecs[i].erv);
      chk($sformatf("row%0d payload", i), {arr_v, arr_wen, arr_bw, arr_idx, arr_way, arr_off, arr_wd},
          exp_pay(vecs[i].erf, vecs[i].ehw, vecs[i].erd, rbeat));
      if (vecs[i].erv) chk($sformatf("row%0d rdata", i), rdata, pat({6'd5, 3'd2, 2'd1}));
      if (vecs[i].erf) rbeat = rbeat + 2'd1;
    end
    // reset during refill beat 2 aborts the burst
    @(negedge clock_i); rf_v = 1; hw_v = 1; rd_v = 0; rf_off = 0;
    #1 rdy("rst beat0", 3'b100);
    @(negedge clock_i); rf_off = 1;
    #1 rdy("rst beat1", 3'b100);
    @(negedge clock_i); rf_off = 2; reset_i = 0;
    #1 rdy("rst mid lock readies", 3'b000);
    chk("rst mid lock array valid", arr_v, 1'b0);
    @(negedge clock_i); reset_i = 1; rf_v = 0;
    #1 rdy("post rst hit write", 3'b010);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock_i); rf_v = 1; rf_off = 2'(b);
      #1 rdy($sformatf("post rst burst beat%0d", b), 3'b100);
    end
    @(negedge clock_i); rf_v = 0;
    #1 rdy("post burst hit write", 3'b010);
    // read return in flight dropped by reset
    @(negedge clock_i); hw_v = 0; rd_v = 1;
    #1 rdy("inflight read grant", 3'b001);
    @(negedge clock_i); rd_v = 0; reset_i = 0;
    #1 chk("inflight rvalid dropped", rvalid, 1'b0);
    @(negedge clock_i); reset_i = 1;
    // write and read to the same location together
    hw_idx = 6'd7; hw_way = 3'd1; hw_off = 2'd3; hw_bw = 16'h00FF;
    rd_idx = 6'd7; rd_way = 3'd1; rd_off = 2'd3;
    w = 128'h0102_0304_0506_0708_A1B2_C3D4_E5F6_0718;
    hw_wd = w;
    hw_v = 1; rd_v = 1;
    #1 rdy("same loc write first", 3'b010);
    @(negedge clock_i); hw_v = 0;
    #1 rdy("same loc read next", 3'b001);
    chk("same loc read payload", {arr_v, arr_wen, arr_bw, arr_idx, arr_way, arr_off, arr_wd},
        {1'b1, 1'b0, 16'h0, 6'd7, 3'd1, 2'd3, 128'h0});
    @(negedge clock_i); rd_v = 0;
    p = pat({6'd7, 3'd1, 2'd3});
    #1 chk("same loc rvalid", rvalid, 1'b1);
    chk("same loc rdata", rdata, {p[127:64], w[63:0]});
    @(negedge clock_i);
    #1 chk("same loc rvalid single", rvalid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
